// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//   Shares a single AXI4 master read channel (AR + R) between two internal
//   requesters. A requester hands over an address and an arlen-encoded beat
//   count; the granted requester then sees the returned R beats on its own
//   valid/ready pair. Only one burst is outstanding at a time, requesters
//   are served round-robin, and the burst ends by internal beat count.
//
// Ports
//   aclk, areset          clock, synchronous active-high reset
//   req_valid/req_ready   per-requester command handshake (ready is one-hot)
//   req_addr, req_len     per-requester byte address and beats-1
//   rsp_valid/rsp_ready   per-requester response beat handshake
//   rsp_data, rsp_resp    shared beat data / rresp, qualified by rsp_valid
//   rsp_last              final beat of the burst by internal count
//   m_ar*                 AXI AR channel (arsize/arburst are constants)
//   m_r*                  AXI R channel
//   err_len               sticky: m_rlast disagreed with the beat count
//   busy                  a burst is being issued or returned
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]          req_len,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_last,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [7:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    output logic                          err_len,
    output logic                          busy
);

    localparam logic [2:0] LP_ARSIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_gnt;       // requester owning the current burst
    logic                    r_prio;      // requester that wins a tie in IDLE
    logic [7:0]              r_cnt;       // beats remaining after the current one
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic [7:0]              r_arlen;
    logic                    r_err_len;

    logic                    w_gnt_sel;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [7:0]              w_sel_len;
    logic                    w_accept;
    logic                    w_beat;
    logic                    w_cnt_zero;

    assign w_cnt_zero = (r_cnt == 8'd0);

    // Round-robin pick: on a tie the requester that was not served last wins
    always_comb begin
        w_gnt_sel = 1'b0;
        if (req_valid[0] && req_valid[1]) begin
            w_gnt_sel = r_prio;
        end else if (req_valid[1]) begin
            w_gnt_sel = 1'b1;
        end else begin
            w_gnt_sel = 1'b0;
        end
    end

    // Command fields of the selected requester
    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = 8'd0;
        if (w_gnt_sel) begin
            w_sel_addr = req_addr[ADDR_WIDTH +: ADDR_WIDTH];
            w_sel_len  = req_len[8 +: 8];
        end else begin
            w_sel_addr = req_addr[0 +: ADDR_WIDTH];
            w_sel_len  = req_len[0 +: 8];
        end
    end

    // FSM state register
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and the combinational handshake/pass-through outputs
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        rsp_valid   = '0;
        rsp_data    = '0;
        rsp_resp    = 2'b00;
        rsp_last    = 1'b0;
        m_rready    = 1'b0;
        w_accept    = 1'b0;
        w_beat      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req_valid) begin
                    w_accept             = 1'b1;
                    req_ready[w_gnt_sel] = 1'b1;
                    w_state_nxt          = S_ADDR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ADDR: begin
                if (m_arready) begin
                    w_state_nxt = S_DATA;
                end else begin
                    w_state_nxt = S_ADDR;
                end
            end
            S_DATA: begin
                // No buffering: the granted requester's ready drives rready
                // directly, so backpressure reaches the slave in-cycle.
                rsp_valid[r_gnt] = m_rvalid;
                m_rready         = rsp_ready[r_gnt];
                rsp_data         = m_rdata;
                rsp_resp         = m_rresp;
                rsp_last         = w_cnt_zero;
                w_beat           = m_rvalid & rsp_ready[r_gnt];
                if (w_beat && w_cnt_zero) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Command latch, beat counter and round-robin priority
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_gnt    <= 1'b0;
            r_prio   <= 1'b0;
            r_cnt    <= 8'd0;
            r_araddr <= '0;
            r_arlen  <= 8'd0;
        end else if (w_accept) begin
            r_gnt    <= w_gnt_sel;
            r_araddr <= w_sel_addr;
            r_arlen  <= w_sel_len;
            r_cnt    <= w_sel_len;
        end else if (w_beat) begin
            // Priority moves only when a burst has fully returned; the
            // requester just served loses the next tie.
            if (w_cnt_zero) begin
                r_prio <= ~r_gnt;
            end else begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    // Sticky length check: rlast must coincide with the final counted beat
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_err_len <= 1'b0;
        end else if (w_beat && (m_rlast != w_cnt_zero)) begin
            r_err_len <= 1'b1;
        end
    end

    assign m_araddr  = r_araddr;
    assign m_arlen   = r_arlen;
    assign m_arsize  = LP_ARSIZE;
    assign m_arburst = 2'b01;
    assign m_arvalid = (r_state == S_ADDR);
    assign err_len   = r_err_len;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter
//   Self-checking bench for axi_rd_arbiter. Inputs are driven on the falling
//   edge, outputs sampled 1 time unit later. A simple AXI slave/requester
//   driver (run_burst) performs one burst and records what it observed; each
//   test task compares those observations against expectations derived from
//   a reference model (grant history, sticky length-error flag).
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter;

    logic        aclk = 1'b0;
    logic        areset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_addr;
    logic [15:0] req_len;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        rsp_last;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready;
    logic        err_len;
    logic        busy;

    always #5 aclk = ~aclk;

    axi_rd_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REQ(2)) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_last(rsp_last),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .err_len(err_len), .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int grant_hist[$];   // requesters granted since reset, oldest first
    bit mdl_err;         // sticky length-error expectation

    // Observations from the last run_burst
    int          cap_gnt;
    int          cap_ready_cycles;
    bit          cap_onehot_bad;
    bit          cap_lat_bad;
    bit          cap_addr_unstable;
    logic [31:0] cap_araddr;
    logic [7:0]  cap_arlen;
    int          cap_beats;
    int          cap_data_bad;
    logic [1:0]  cap_resp[$];
    int          cap_last_count;
    int          cap_last_pos;
    bit          cap_wrong_valid;
    int          cap_mirror_bad;
    bit          cap_timeout;
    bit          cap_err_before[$];
    logic        cap_busy_after;
    logic        cap_err_after;

    // Round-robin rule: a lone requester wins; on a tie the one not granted
    // last wins, and requester 0 wins the first tie after reset.
    function automatic int model_winner(input logic [1:0] vm);
        if (vm == 2'b11) begin
            if (grant_hist.size() == 0) return 0;
            return 1 - grant_hist[grant_hist.size()-1];
        end else if (vm == 2'b10) begin
            return 1;
        end
        return 0;
    endfunction

    task automatic apply_reset();
        @(negedge aclk);
        areset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00; m_arready = 1'b0;
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        grant_hist.delete();
        mdl_err = 1'b0;
    endtask

    // Drives one complete burst: command from vm, AR handshake after
    // ar_delay stall cycles, nbeats R beats. ready_mode 0=always ready,
    // 1=toggle rsp_ready, 2=random valid/ready. rlast is driven on beat
    // last_at, SLVERR on beat err_at. cut_at>0 returns right after that
    // many beats are sampled, leaving the burst unfinished.
    task automatic run_burst(input logic [1:0] vm, input int g, input int nbeats,
                             input int ar_delay, input int last_at, input int ready_mode,
                             input int err_at, input int cut_at, input bit hold);
        int          cyc;
        int          beat;
        logic [31:0] a0;
        logic [31:0] sent;
        bit          rv;
        bit          rr;
        cap_gnt = -1; cap_ready_cycles = 0; cap_onehot_bad = 0; cap_lat_bad = 0;
        cap_addr_unstable = 0; cap_beats = 0; cap_data_bad = 0; cap_resp.delete();
        cap_last_count = 0; cap_last_pos = -1; cap_wrong_valid = 0; cap_mirror_bad = 0;
        cap_timeout = 0; cap_err_before.delete(); a0 = 32'h0;
        @(negedge aclk);
        req_valid = vm;
        #1;
        cyc = 0;
        while (req_ready == 2'b00 && cyc < 8) begin
            @(negedge aclk); cyc++; #1;
        end
        if (req_ready == 2'b00) begin
            cap_timeout = 1; req_valid = 2'b00; return;
        end
        cap_gnt = req_ready[1] ? 1 : 0;
        cap_onehot_bad = !$onehot(req_ready);
        cap_ready_cycles = 1;
        for (int d = 0; d <= ar_delay; d++) begin
            @(negedge aclk);
            req_valid = hold ? vm : 2'b00;
            m_arready = (d == ar_delay);
            #1;
            if (d == 0) begin
                a0 = m_araddr;
                cap_lat_bad = (m_arvalid !== 1'b1);
            end
            if (m_araddr !== a0 || m_arvalid !== 1'b1) cap_addr_unstable = 1;
            if (req_ready != 2'b00) cap_ready_cycles++;
        end
        cap_araddr = m_araddr;
        cap_arlen  = m_arlen;
        beat = 0;
        cyc  = 0;
        while (beat < nbeats && cyc < 300) begin
            @(negedge aclk);
            m_arready = 1'b0;
            req_valid = hold ? vm : 2'b00;
            rv = (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            rr = (ready_mode == 1) ? (cyc % 2 == 0) :
                 (ready_mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
            rsp_ready[g]     = rr;
            rsp_ready[1 - g] = 1'($urandom_range(0, 1));
            sent     = $urandom;
            m_rvalid = rv;
            m_rdata  = sent;
            m_rlast  = (beat == last_at);
            m_rresp  = (beat == err_at) ? 2'b10 : 2'b00;
            #1;
            if (m_rready !== rr) cap_mirror_bad++;
            if (rsp_valid[g] !== rv || rsp_valid[1 - g] !== 1'b0) cap_wrong_valid = 1;
            if (req_ready != 2'b00) cap_ready_cycles++;
            if (m_rvalid && m_rready === 1'b1) begin
                if (rsp_data !== sent) cap_data_bad++;
                cap_resp.push_back(rsp_resp);
                if (rsp_last === 1'b1) begin
                    cap_last_count++;
                    cap_last_pos = beat;
                end
                cap_err_before.push_back(err_len);
                beat++;
                cap_beats = beat;
                if (beat == cut_at) return;
            end
            cyc++;
        end
        if (beat < nbeats) cap_timeout = 1;
        @(negedge aclk);
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00; rsp_ready = 2'b00; req_valid = 2'b00;
        #1;
        cap_busy_after = busy;
        cap_err_after  = err_len;
        grant_hist.push_back(g);
        for (int i = 0; i < nbeats; i++)
            if ((i == last_at) != (i == nbeats - 1)) mdl_err = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
        checks++; if (m_arvalid !== 1'b0 || m_rready !== 1'b0) begin errors++; $display("FAIL reset_axi_valid_ready: got arvalid=%b rready=%b want 0/0", m_arvalid, m_rready); end
        checks++; if (busy !== 1'b0 || err_len !== 1'b0) begin errors++; $display("FAIL reset_busy_err: got busy=%b err=%b want 0/0", busy, err_len); end
        checks++; if (m_araddr !== 32'h0 || m_arlen !== 8'h0 || rsp_last !== 1'b0) begin errors++; $display("FAIL reset_outputs_zero: got araddr=%h arlen=%h last=%b want 0", m_araddr, m_arlen, rsp_last); end
        checks++; if (m_arsize !== 3'd2 || m_arburst !== 2'b01) begin errors++; $display("FAIL reset_constants: got arsize=%0d arburst=%0d want 2/1", m_arsize, m_arburst); end
    endtask

    task automatic test_single_read();
        int g;
        req_addr[31:0] = 32'h0000_1000;
        req_len[7:0]   = 8'd3;
        g = model_winner(2'b01);
        run_burst(2'b01, g, 4, 0, 3, 0, -1, -1, 1'b0);
        checks++; if (cap_timeout !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b want 0", cap_timeout); end
        checks++; if (cap_gnt !== g || cap_onehot_bad) begin errors++; $display("FAIL single_grant: got %0d want %0d", cap_gnt, g); end
        checks++; if (cap_lat_bad !== 1'b0) begin errors++; $display("FAIL single_arvalid_latency: arvalid not high 1 cycle after accept"); end
        checks++; if (cap_araddr !== 32'h1000 || cap_arlen !== 8'd3) begin errors++; $display("FAIL single_ar_fields: got %h/%0d want 1000/3", cap_araddr, cap_arlen); end
        checks++; if (m_arsize !== 3'd2 || m_arburst !== 2'b01) begin errors++; $display("FAIL single_ar_const: got %0d/%0d want 2/1", m_arsize, m_arburst); end
        checks++; if (cap_beats !== 4 || cap_data_bad !== 0 || cap_wrong_valid) begin errors++; $display("FAIL single_beats: got beats=%0d bad=%0d wrongvalid=%b want 4/0/0", cap_beats, cap_data_bad, cap_wrong_valid); end
        checks++; if (cap_last_count !== 1 || cap_last_pos !== 3) begin errors++; $display("FAIL single_rsp_last: got count=%0d pos=%0d want 1/3", cap_last_count, cap_last_pos); end
        checks++; if (cap_err_after !== mdl_err || cap_busy_after !== 1'b0) begin errors++; $display("FAIL single_end_state: got err=%b busy=%b want %b/0", cap_err_after, cap_busy_after, mdl_err); end
        checks++; if (cap_ready_cycles !== 1) begin errors++; $display("FAIL single_req_ready_pulse: got %0d cycles want 1", cap_ready_cycles); end
    endtask

    task automatic test_contention();
        int g;
        apply_reset();
        req_addr = {32'h0000_B000, 32'h0000_A000};
        req_len  = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            g = model_winner(2'b11);
            run_burst(2'b11, g, 1, 0, 0, 0, -1, -1, 1'b1);
            checks++; if (cap_gnt !== g || cap_onehot_bad) begin errors++; $display("FAIL contention_grant[%0d]: got %0d want %0d", k, cap_gnt, g); end
            checks++; if (cap_ready_cycles !== 1) begin errors++; $display("FAIL contention_ready_pulse[%0d]: got %0d cycles want 1", k, cap_ready_cycles); end
            checks++; if (cap_araddr !== (g == 1 ? 32'h0000_B000 : 32'h0000_A000) || cap_busy_after !== 1'b0) begin errors++; $display("FAIL contention_addr[%0d]: got %h busy=%b", k, cap_araddr, cap_busy_after); end
        end
    endtask

    task automatic test_backpressure();
        int g;
        req_addr[63:32] = 32'h2000_0040;
        req_len[15:8]   = 8'd7;
        g = model_winner(2'b10);
        run_burst(2'b10, g, 8, 5, 7, 1, -1, -1, 1'b0);
        checks++; if (cap_gnt !== g || cap_timeout) begin errors++; $display("FAIL bp_grant: got %0d timeout=%b want %0d", cap_gnt, cap_timeout, g); end
        checks++; if (cap_addr_unstable !== 1'b0) begin errors++; $display("FAIL bp_araddr_stable: address or arvalid changed before handshake"); end
        checks++; if (cap_araddr !== 32'h2000_0040 || cap_arlen !== 8'd7) begin errors++; $display("FAIL bp_ar_fields: got %h/%0d want 20000040/7", cap_araddr, cap_arlen); end
        checks++; if (cap_mirror_bad !== 0) begin errors++; $display("FAIL bp_rready_mirror: got %0d bad cycles want 0", cap_mirror_bad); end
        checks++; if (cap_beats !== 8 || cap_data_bad !== 0 || cap_wrong_valid) begin errors++; $display("FAIL bp_beats: got beats=%0d bad=%0d want 8/0", cap_beats, cap_data_bad); end
        checks++; if (cap_last_pos !== 7 || cap_busy_after !== 1'b0) begin errors++; $display("FAIL bp_last: got pos=%0d busy=%b want 7/0", cap_last_pos, cap_busy_after); end
    endtask

    task automatic test_err_passthrough();
        int g;
        req_addr[31:0] = 32'h0000_3000;
        req_len[7:0]   = 8'd1;
        g = model_winner(2'b01);
        run_burst(2'b01, g, 2, 1, 1, 0, 0, -1, 1'b0);
        checks++; if (cap_beats !== 2 || cap_resp.size() !== 2 || cap_busy_after !== 1'b0) begin errors++; $display("FAIL errpass_complete: got beats=%0d busy=%b want 2/0", cap_beats, cap_busy_after); end
        if (cap_resp.size() == 2) begin
            checks++; if (cap_resp[0] !== 2'b10) begin errors++; $display("FAIL errpass_resp0: got %b want 10", cap_resp[0]); end
            checks++; if (cap_resp[1] !== 2'b00) begin errors++; $display("FAIL errpass_resp1: got %b want 00", cap_resp[1]); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            logic [1:0]  vm;
            logic [31:0] ad0, ad1, exp_addr;
            logic [7:0]  ln0, ln1, exp_len;
            int          g, nb, ea, rbad;
            vm  = 2'($urandom_range(1, 3));
            ad0 = $urandom & 32'hFFFF_F000;
            ad1 = $urandom & 32'hFFFF_F000;
            ln0 = 8'($urandom_range(0, 7));
            ln1 = 8'($urandom_range(0, 7));
            req_addr = {ad1, ad0};
            req_len  = {ln1, ln0};
            g = model_winner(vm);
            exp_addr = (g == 1) ? ad1 : ad0;
            exp_len  = (g == 1) ? ln1 : ln0;
            nb = int'(exp_len) + 1;
            ea = $urandom_range(0, nb);
            run_burst(vm, g, nb, $urandom_range(0, 3), nb - 1, 2, ea, -1, 1'($urandom_range(0, 1)));
            rbad = 0;
            for (int i = 0; i < cap_resp.size(); i++)
                if (cap_resp[i] !== ((i == ea) ? 2'b10 : 2'b00)) rbad++;
            checks++; if (cap_gnt !== g || cap_timeout) begin errors++; $display("FAIL rand_grant[%0d]: got %0d timeout=%b want %0d (vm=%b)", n, cap_gnt, cap_timeout, g, vm); end
            checks++; if (cap_araddr !== exp_addr || cap_arlen !== exp_len) begin errors++; $display("FAIL rand_ar[%0d]: got %h/%0d want %h/%0d", n, cap_araddr, cap_arlen, exp_addr, exp_len); end
            checks++; if (cap_beats !== nb || cap_data_bad !== 0 || rbad !== 0) begin errors++; $display("FAIL rand_beats[%0d]: got beats=%0d databad=%0d respbad=%0d want %0d/0/0", n, cap_beats, cap_data_bad, rbad, nb); end
            checks++; if (cap_last_count !== 1 || cap_last_pos !== nb - 1) begin errors++; $display("FAIL rand_last[%0d]: got count=%0d pos=%0d want 1/%0d", n, cap_last_count, cap_last_pos, nb - 1); end
            checks++; if (cap_wrong_valid || cap_mirror_bad !== 0 || cap_ready_cycles !== 1) begin errors++; $display("FAIL rand_handshake[%0d]: got wrongvalid=%b mirrorbad=%0d readycycles=%0d want 0/0/1", n, cap_wrong_valid, cap_mirror_bad, cap_ready_cycles); end
            checks++; if (cap_busy_after !== 1'b0 || cap_err_after !== mdl_err) begin errors++; $display("FAIL rand_end[%0d]: got busy=%b err=%b want 0/%b", n, cap_busy_after, cap_err_after, mdl_err); end
        end
    endtask

    task automatic test_len_error();
        int g;
        bit prior;
        bit exp_k;
        req_addr[31:0] = 32'h0000_4000;
        req_len[7:0]   = 8'd3;
        g = model_winner(2'b01);
        prior = mdl_err;
        run_burst(2'b01, g, 4, 0, 1, 0, -1, -1, 1'b0);
        checks++; if (cap_beats !== 4 || cap_last_pos !== 3 || cap_busy_after !== 1'b0) begin errors++; $display("FAIL lenerr_complete: got beats=%0d lastpos=%0d busy=%b want 4/3/0", cap_beats, cap_last_pos, cap_busy_after); end
        if (cap_err_before.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                exp_k = prior;
                for (int i = 0; i < k; i++)
                    if ((i == 1) != (i == 3)) exp_k = 1'b1;
                checks++; if (cap_err_before[k] !== exp_k) begin errors++; $display("FAIL lenerr_flag_beat%0d: got %b want %b", k + 1, cap_err_before[k], exp_k); end
            end
        end
        checks++; if (cap_err_after !== mdl_err) begin errors++; $display("FAIL lenerr_sticky: got %b want %b", cap_err_after, mdl_err); end
    endtask

    task automatic test_reset_mid_burst();
        int g;
        req_addr[31:0] = 32'h0000_5000;
        req_len[7:0]   = 8'd7;
        run_burst(2'b01, model_winner(2'b01), 8, 0, 7, 0, -1, 1, 1'b0);
        @(negedge aclk);
        areset = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h1234_5678; rsp_ready = 2'b01;
        @(negedge aclk);
        areset = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; rsp_ready = 2'b00; req_valid = 2'b00;
        grant_hist.delete();
        mdl_err = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || m_arvalid !== 1'b0 || m_rready !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: got busy=%b arvalid=%b rready=%b want 0", busy, m_arvalid, m_rready); end
        checks++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00 || err_len !== 1'b0) begin errors++; $display("FAIL midreset_req_rsp: got rspv=%b reqr=%b err=%b want 0", rsp_valid, req_ready, err_len); end
        checks++; if (m_araddr !== 32'h0 || rsp_last !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got araddr=%h last=%b want 0", m_araddr, rsp_last); end
        req_addr[63:32] = 32'h0000_6000;
        req_len[15:8]   = 8'd2;
        g = model_winner(2'b10);
        run_burst(2'b10, g, 3, 0, 2, 0, -1, -1, 1'b0);
        checks++; if (cap_gnt !== g || cap_araddr !== 32'h0000_6000) begin errors++; $display("FAIL midreset_next_grant: got %0d/%h want %0d/00006000", cap_gnt, cap_araddr, g); end
        checks++; if (cap_beats !== 3 || cap_data_bad !== 0 || cap_busy_after !== 1'b0) begin errors++; $display("FAIL midreset_next_burst: got beats=%0d bad=%0d busy=%b want 3/0/0", cap_beats, cap_data_bad, cap_busy_after); end
    endtask

    initial begin
        areset = 1'b1; req_valid = 2'b00; req_addr = 64'h0; req_len = 16'h0;
        rsp_ready = 2'b00; m_arready = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
        m_rlast = 1'b0; m_rvalid = 1'b0; mdl_err = 1'b0;
        test_reset();
        test_single_read();
        test_contention();
        test_backpressure();
        test_err_passthrough();
        test_random();
        test_len_error();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
